// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int width_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Multi-stage synchronizer for the asynchronous active-low reset request.
// Reset presets every stage to the "request active" value.
module reset_req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_n_async_i,
    output logic req_n_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_n_async_i};
    end

    // NOTE: clocked state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign req_n_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Asserts all per-subsystem resets together, then releases them one at a time
// in index order after a minimum stretch, optionally gated by acknowledges.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 8,
    parameter bit WAIT_ACK       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rst_req_n_async,
    input  logic                    sw_reset,
    input  logic [NUM_CHANNELS-1:0] ch_ack,
    output logic [NUM_CHANNELS-1:0] rst_n_out,
    output logic                    busy,
    output logic                    all_released
);

    localparam int CNT_W = width_min1((STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES);
    localparam int IDX_W = width_min1(NUM_CHANNELS);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CHANNELS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] rst_n_q, rst_n_d;

    logic                    req_n_sync;
    logic                    request;
    logic [2**IDX_W-1:0]     ack_ext;
    logic                    ack_ok;
    logic [IDX_W-1:0]        idx_next;

    reset_req_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk          (clk),
        .reset        (reset),
        .req_n_async_i(rst_req_n_async),
        .req_n_sync_o (req_n_sync)
    );

    assign request  = reset | ~req_n_sync | sw_reset;
    assign idx_next = idx_q + 1'b1;

    // Pad the acknowledge vector so idx can address it for any channel count.
    always_comb begin
        ack_ext                   = '0;
        ack_ext[NUM_CHANNELS-1:0] = ch_ack;
        ack_ok                    = !WAIT_ACK || ack_ext[idx_q];
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;

        unique case (state_q)
            ST_ASSERT: begin
                if (cnt_q == STRETCH_LAST) begin
                    state_d = (NUM_CHANNELS == 1) ? ST_DONE : ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = NUM_CHANNELS'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    if (ack_ok) begin
                        // Outputs form a thermometer code, so releasing idx+1 shifts in a one.
                        rst_n_d = NUM_CHANNELS'({rst_n_q, 1'b1});
                        idx_d   = idx_next;
                        cnt_d   = '0;
                        if (idx_next == IDX_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                rst_n_d = '1;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (request) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign rst_n_out    = rst_n_q;
    assign busy         = (state_q != ST_DONE);
    assign all_released = (state_q == ST_DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: fixed vectors, hand-written corner sequences and
// randomized traffic on three configurations against a timestamp-based model.
module tb_reset_sequencer;

    localparam int NDUT   = 3;
    localparam int SYNC   = 2;
    localparam int LOGLEN = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_v [NDUT];
    logic       sw_v    [NDUT];
    logic       async_v [NDUT];
    logic [3:0] ack_v   [NDUT];

    logic [3:0] rno0, rno1;
    logic [0:0] rno2;
    logic       busy0, busy1, busy2;
    logic       all0, all1, all2;

    int checks = 0;
    int errors = 0;

    // dut 0: defaults; dut 1: acknowledge-gated; dut 2: single channel, one-cycle stretch
    reset_sequencer u_dut0 (
        .clk(clk), .reset(reset_v[0]), .rst_req_n_async(async_v[0]), .sw_reset(sw_v[0]),
        .ch_ack(ack_v[0]), .rst_n_out(rno0), .busy(busy0), .all_released(all0)
    );

    reset_sequencer #(.WAIT_ACK(1'b1)) u_dut1 (
        .clk(clk), .reset(reset_v[1]), .rst_req_n_async(async_v[1]), .sw_reset(sw_v[1]),
        .ch_ack(ack_v[1]), .rst_n_out(rno1), .busy(busy1), .all_released(all1)
    );

    reset_sequencer #(.NUM_CHANNELS(1), .STRETCH_CYCLES(1)) u_dut2 (
        .clk(clk), .reset(reset_v[2]), .rst_req_n_async(async_v[2]), .sw_reset(sw_v[2]),
        .ch_ack(ack_v[2][0:0]), .rst_n_out(rno2), .busy(busy2), .all_released(all2)
    );

    function automatic int cfg_n(input int d);
        return (d == 2) ? 1 : 4;
    endfunction
    function automatic int cfg_s(input int d);
        return (d == 2) ? 1 : 16;
    endfunction
    function automatic int cfg_g(input int d);
        return (d == 2) ? 8 : 8;
    endfunction
    function automatic bit cfg_w(input int d);
        return (d == 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks when the last request happened, when the last
    // channel was released, and how many channels are out of reset.
    int  now = 0;
    int  last_rst [NDUT];
    int  last_req [NDUT];
    int  last_rel [NDUT];
    int  released [NDUT];
    bit  en       [NDUT];
    bit  async_log[NDUT][0:LOGLEN-1];

    task automatic model_step();
        bit sync_req;
        bit req;
        now++;
        for (int d = 0; d < NDUT; d++) begin
            if (now < LOGLEN) async_log[d][now] = async_v[d];
            if (reset_v[d]) begin
                last_rst[d] = now;
                en[d]       = 1'b1;
            end
            // The synchronized request reflects the input SYNC edges ago, or is
            // forced active for SYNC edges after a power-on reset.
            sync_req = ((now - last_rst[d]) <= SYNC) ||
                       ((now - SYNC) >= 0 && !async_log[d][now - SYNC]);
            req = reset_v[d] || sync_req || sw_v[d];
            if (req) begin
                released[d] = 0;
                last_req[d] = now;
            end else if (released[d] == 0) begin
                if (now - last_req[d] >= cfg_s(d)) begin
                    released[d] = 1;
                    last_rel[d] = now;
                end
            end else if (released[d] < cfg_n(d)) begin
                if ((now - last_rel[d] >= cfg_g(d)) &&
                    (!cfg_w(d) || ack_v[d][released[d]-1] == 1'b1)) begin
                    released[d]++;
                    last_rel[d] = now;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_obs(input int d);
        int r;
        logic [3:0] rn;
        r  = released[d];
        rn = 4'((1 << r) - 1);
        return {26'd0, rn, (r < cfg_n(d)), (r == cfg_n(d))};
    endfunction

    function automatic logic [31:0] act_obs(input int d);
        case (d)
            0:       return {26'd0, rno0, busy0, all0};
            1:       return {26'd0, rno1, busy1, all1};
            default: return {26'd0, 3'd0, rno2, busy2, all2};
        endcase
    endfunction

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            last_rst[d] = -100;
            last_req[d] = 0;
            last_rel[d] = 0;
            released[d] = 0;
            en[d]       = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (en[d]) check($sformatf("model_dut%0d_t%0d", d, now), act_obs(d), exp_obs(d));
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       sw;
        logic       an;
        int         n;
        logic [3:0] rn;
        logic       busy;
        logic       all_rel;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;

    task automatic add(input logic rst, input logic sw, input logic an, input int n,
                       input logic [3:0] rn, input logic b, input logic a);
        vecs[nvec] = '{rst: rst, sw: sw, an: an, n: n, rn: rn, busy: b, all_rel: a};
        nvec++;
    endtask

    initial begin
        bit found;
        int k;

        // power-on: sync stages are preset active, so the stretch ends 2 edges later
        add(1, 0, 1,  2, 4'b0000, 1, 0);
        add(0, 0, 1, 17, 4'b0000, 1, 0);
        add(0, 0, 1,  1, 4'b0001, 1, 0);
        add(0, 0, 1,  7, 4'b0001, 1, 0);
        add(0, 0, 1,  1, 4'b0011, 1, 0);
        add(0, 0, 1,  8, 4'b0111, 1, 0);
        add(0, 0, 1,  7, 4'b0111, 1, 0);
        add(0, 0, 1,  1, 4'b1111, 0, 1);
        add(0, 0, 1,  5, 4'b1111, 0, 1);
        // software reset in DONE
        add(0, 1, 1,  1, 4'b0000, 1, 0);
        add(0, 0, 1, 15, 4'b0000, 1, 0);
        add(0, 0, 1,  1, 4'b0001, 1, 0);
        add(0, 0, 1,  8, 4'b0011, 1, 0);
        // software reset mid-release; index and counter restart
        add(0, 1, 1,  1, 4'b0000, 1, 0);
        add(0, 0, 1, 15, 4'b0000, 1, 0);
        add(0, 0, 1,  1, 4'b0001, 1, 0);
        add(0, 0, 1,  7, 4'b0001, 1, 0);
        add(0, 0, 1,  1, 4'b0011, 1, 0);
        // async request held low for five edges
        add(0, 0, 0,  2, 4'b0011, 1, 0);
        add(0, 0, 0,  1, 4'b0000, 1, 0);
        add(0, 0, 0,  2, 4'b0000, 1, 0);
        add(0, 0, 1, 17, 4'b0000, 1, 0);
        add(0, 0, 1,  1, 4'b0001, 1, 0);
        // request on the same edge as a due release
        add(0, 0, 1,  7, 4'b0001, 1, 0);
        add(0, 1, 1,  1, 4'b0000, 1, 0);
        add(0, 0, 1, 16, 4'b0001, 1, 0);
        add(0, 0, 1, 23, 4'b0111, 1, 0);
        add(0, 0, 1,  1, 4'b1111, 0, 1);

        for (int d = 0; d < NDUT; d++) begin
            reset_v[d] = 1'b1;
            sw_v[d]    = 1'b0;
            async_v[d] = 1'b1;
            ack_v[d]   = 4'b1111;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) reset_v[d] = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            reset_v[0] = vecs[i].rst;
            sw_v[0]    = vecs[i].sw;
            async_v[0] = vecs[i].an;
            repeat (vecs[i].n) @(negedge clk);
            check($sformatf("vec%0d", i), {26'd0, rno0, busy0, all0},
                  {26'd0, vecs[i].rn, vecs[i].busy, vecs[i].all_rel});
        end
        reset_v[0] = 1'b0;
        sw_v[0]    = 1'b0;
        async_v[0] = 1'b1;

        // late acknowledge on channel 1 of the gated instance
        ack_v[1]   = 4'b1101;
        reset_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        reset_v[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (rno1 == 4'b0011) found = 1'b1;
        end
        check("ack_wait_ch1_seen", {31'd0, found}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("ack_hold_%0d", c), {27'd0, rno1, busy1}, {27'd0, 4'b0011, 1'b1});
        end
        ack_v[1][1] = 1'b1;
        @(negedge clk);
        check("ack_late_release", {27'd0, rno1, busy1}, {27'd0, 4'b0111, 1'b1});
        ack_v[1] = 4'b1111;

        // single channel, one-cycle stretch: release lands SYNC+1 edges after reset
        reset_v[2] = 1'b1;
        repeat (2) @(negedge clk);
        reset_v[2] = 1'b0;
        k = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            k++;
            if (rno2 == 1'b1) found = 1'b1;
        end
        check("single_release_edges", k, SYNC + 1);
        check("single_flags", {30'd0, busy2, all2}, {30'd0, 1'b0, 1'b1});

        // randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                reset_v[d] = ($urandom_range(0, 399) == 0);
                sw_v[d]    = ($urandom_range(0, 149) == 0);
                if (async_v[d]) async_v[d] = ($urandom_range(0, 79) != 0);
                else            async_v[d] = ($urandom_range(0, 2) == 0);
                for (int b = 0; b < 4; b++) ack_v[d][b] = ($urandom_range(0, 7) != 0);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            reset_v[d] = 1'b0;
            sw_v[d]    = 1'b0;
            async_v[d] = 1'b1;
            ack_v[d]   = 4'b1111;
        end
        repeat (80) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
